// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: one requester at a time owns the FIFO write port
// for up to max_burst words, then ownership rotates to the next valid requester.
module fifo_wr_arbiter #(
    parameter int unsigned width     = 8,
    parameter int unsigned n_req     = 4,
    parameter int unsigned max_burst = 4
) (
    input  logic                     w_clk,
    input  logic                     rst_w_n,
    input  logic [n_req-1:0]         req_valid,
    input  logic [n_req*width-1:0]   req_data,
    output logic [n_req-1:0]         req_ready,
    input  logic                     full,
    output logic                     w_en,
    output logic [width-1:0]         w_data,
    output logic [n_req-1:0]         grant,
    output logic [$clog2(n_req)-1:0] grant_id,
    output logic                     busy
);
    localparam int unsigned ID_W  = $clog2(n_req);
    localparam int unsigned CNT_W = $clog2(max_burst) + 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state_q, state_d;
    logic [n_req-1:0] grant_q, grant_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [ID_W-1:0]  last_id_q, last_id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             owner_valid;
    logic             xfer;
    logic             hi_found;
    logic             lo_found;
    logic [ID_W-1:0]  hi_id;
    logic [ID_W-1:0]  lo_id;
    logic [ID_W-1:0]  sel_id;

    always_ff @(posedge w_clk) begin
        if (!rst_w_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            last_id_q  <= ID_W'(n_req - 1);
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            cnt_q      <= cnt_d;
        end
    end

    // Round-robin pick: lowest valid index above last_id, else lowest valid overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = 0; i < int'(n_req); i++) begin
            if (req_valid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_id    = ID_W'(i);
            end
            if (req_valid[i] && !hi_found && (ID_W'(i) > last_id_q)) begin
                hi_found = 1'b1;
                hi_id    = ID_W'(i);
            end
        end
        sel_id = hi_found ? hi_id : lo_id;
    end

    // Write-port datapath; everything is forced quiet while reset is asserted.
    always_comb begin
        owner_valid = |(req_valid & grant_q);
        busy        = rst_w_n && (state_q == GRANT);
        xfer        = busy && owner_valid && !full;
        w_en        = xfer;
        req_ready   = xfer ? grant_q : '0;
        w_data      = '0;
        for (int i = 0; i < int'(n_req); i++) begin
            if (busy && (grant_id_q == ID_W'(i))) begin
                w_data = req_data[i*width +: width];
            end
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d    = GRANT;
                    grant_id_d = sel_id;
                    grant_d    = n_req'(1) << sel_id;
                    cnt_d      = '0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Release on a burst-completing write or when the owner runs dry.
                if (!owner_valid ||
                    (xfer && ((cnt_q + CNT_W'(1)) == CNT_W'(max_burst)))) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    last_id_d = grant_id_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: width, default 8, data word width in bits, matching the FIFO write port.
REQ-002 Parameter: n_req, default 4, number of requesters (2..8).
REQ-003 Parameter: max_burst, default 4, maximum transfers per grant (1..16).
REQ-004 Port: w_clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-005 Port: rst_w_n  input  1  reset, synchronous, active-low.
REQ-006 Port: req_valid  input  n_req  per-requester word-available flag.
REQ-007 Port: req_data  input  n_req*width  requester i data at bits [i*width +: width].
REQ-008 Port: req_ready  output  n_req  per-requester word-accepted strobe.
REQ-009 Port: full  input  1  FIFO full flag, synchronous to w_clk.
REQ-010 Port: w_en  output  1  FIFO write enable.
REQ-011 Port: w_data  output  width  FIFO write data.
REQ-012 Port: grant  output  n_req  one-hot current owner; all-zero when idle.
REQ-013 Port: grant_id  output  $clog2(n_req)  index of current or last owner.
REQ-014 Port: busy  output  1  high while in GRANT state.

Function
REQ-015 FSM SHALL have exactly two states: IDLE and GRANT.
REQ-016 In IDLE with any req_valid bit high, the block SHALL select the first valid requester searching upward from last_id+1 modulo n_req (round-robin).
REQ-017 The selection SHALL be registered: grant, grant_id, and a GRANT state SHALL appear on the next edge, giving 1-cycle arbitration latency.
REQ-018 In IDLE with no req_valid bit high, the block SHALL stay in IDLE with grant held at zero.
REQ-019 Transfer condition: state GRANT && req_valid[grant_id] && !full.
REQ-020 w_en SHALL equal the transfer condition combinationally.
REQ-021 req_ready[grant_id] SHALL equal the transfer condition; all other req_ready bits SHALL be 0.
REQ-022 w_data SHALL equal the grant_id slice of req_data in GRANT and SHALL be 0 in IDLE.
REQ-023 A burst counter (width $clog2(max_burst)+1) SHALL clear on entry to GRANT and increment by 1 per transfer.
REQ-024 Release: GRANT SHALL go to IDLE on the edge on which either a transfer makes the count equal max_burst, or req_valid[grant_id] is low.
REQ-025 On release, last_id SHALL be set to grant_id and grant SHALL clear.
REQ-026 While full is high in GRANT, the block SHALL hold ownership; the counter SHALL hold, w_en SHALL stay 0, and there SHALL be no timeout.
REQ-027 A requester dropping req_valid while stalled by full SHALL cause release per REQ-024.
REQ-028 Non-granted requesters' req_valid changes SHALL have no effect until the next IDLE arbitration.
REQ-029 Only the owner's word SHALL ever be written; at most one write SHALL occur per cycle.

Reset
REQ-030 While rst_w_n is low at a rising edge, the following SHALL be set: state=IDLE, grant=0, grant_id=0, last_id=n_req-1, and burst counter=0.
REQ-031 Reset SHALL take priority over any in-progress burst, which SHALL be abandoned with no further w_en.
REQ-032 During and immediately after reset, outputs SHALL be w_en=0, req_ready=0, busy=0, and w_data=0.

Verification
REQ-033 Reset, then req_valid=4'b0001 held high, full=0: expect grant=0001 one cycle later, then 4 consecutive w_en pulses, release, IDLE for 1 cycle, then re-grant to requester 0.
REQ-034 req_valid=4'b1111 held high, full=0: expect grant order 0,1,2,3,0, with 4 writes each and w_data matching each owner's slice.
REQ-035 Requester 2 granted, full raised after 2 writes for 5 cycles: expect w_en=0 and req_ready=0 for those cycles, grant held, then 2 more writes, then release.
REQ-036 Requester 1 granted, req_valid[1] dropped after 1 write: expect release on that edge, burst count 1, and the next grant going to the next valid requester above 1.
REQ-037 rst_w_n pulsed low mid-burst (owner 3, count 2): expect grant=0 and w_en=0 on the following cycle, and the next arbitration with all requesters valid granting requester 0.
